// File: rtl/dmem_pkg.sv
// Shared types for the data-memory load/store unit: access size encoding and
// controller states.
package dmem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10,
        MEM_BAD  = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } lsu_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the LSU: store byte enables and lane replication,
// plus lane extraction and sign/zero extension of load data.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  mem_size_e   size,
    input  logic [1:0]  offset,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rword[7:0];
        case (offset)
            2'd0: byte_sel = rword[7:0];
            2'd1: byte_sel = rword[15:8];
            2'd2: byte_sel = rword[23:16];
            2'd3: byte_sel = rword[31:24];
            default: byte_sel = rword[7:0];
        endcase
        half_sel = offset[1] ? rword[31:16] : rword[15:0];
    end

    always_comb begin
        be         = 4'b0000;
        wdata_lane = wdata;
        load_data  = 32'h0;
        case (size)
            MEM_BYTE: begin
                be         = 4'b0001 << offset;
                wdata_lane = {4{wdata[7:0]}};
                load_data  = {{24{byte_sel[7] & ~uns}}, byte_sel};
            end
            MEM_HALF: begin
                be         = offset[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                load_data  = {{16{half_sel[15] & ~uns}}, half_sel};
            end
            MEM_WORD: begin
                be         = 4'b1111;
                wdata_lane = wdata;
                load_data  = rword;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_lsu.sv
// Word-organised data memory with a byte/half/word load-store front end and
// configurable wait states. Define DMEM_ERR_EN to flag misaligned/illegal accesses.
module data_mem_lsu
    import dmem_pkg::*;
#(
    parameter int MEM_SIZE_IN_KB = 1,
    parameter int WAIT_STATES    = 0
)
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int NO_OF_WORDS = MEM_SIZE_IN_KB * 256;
    localparam int AW          = $clog2(NO_OF_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    lsu_state_e  state_q, state_d;
    logic [3:0]  cnt_q;
    logic        accept, commit;

    logic [AW+1:0] addr_q;
    logic          we_q, unsigned_q;
    mem_size_e     size_q;
    logic [31:0]   wdata_q;

    logic [AW+1:0] a_addr;
    logic          a_we, a_unsigned;
    mem_size_e     a_size, eff_size;
    logic [31:0]   a_wdata;
    logic [1:0]    eff_off;
    logic          acc_err;

    logic [31:0] mem [NO_OF_WORDS];
    logic [AW-1:0] idx;
    logic [31:0] rword, wdata_lane, load_data, wr_word;
    logic [3:0]  be;

    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_i[31:AW+2];

    assign accept = req_i && ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
            ST_WAIT: if (cnt_q == 4'd0) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 4'd0;
        end else if (state_q == ST_IDLE && accept) begin
            cnt_q <= WAIT_INIT;
        end else if (state_q == ST_WAIT && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q     <= '0;
            we_q       <= 1'b0;
            size_q     <= MEM_BYTE;
            unsigned_q <= 1'b0;
            wdata_q    <= 32'h0;
        end else if (accept) begin
            addr_q     <= addr_i[AW+1:0];
            we_q       <= we_i;
            size_q     <= mem_size_e'(size_i);
            unsigned_q <= unsigned_i;
            wdata_q    <= wdata_i;
        end
    end

    // With no wait states the access completes on the acceptance edge itself,
    // so the live request fields are used while still in IDLE.
    always_comb begin
        if (state_q == ST_IDLE) begin
            a_addr     = addr_i[AW+1:0];
            a_we       = we_i;
            a_size     = mem_size_e'(size_i);
            a_unsigned = unsigned_i;
            a_wdata    = wdata_i;
        end else begin
            a_addr     = addr_q;
            a_we       = we_q;
            a_size     = size_q;
            a_unsigned = unsigned_q;
            a_wdata    = wdata_q;
        end
    end

    always_comb begin
        acc_err  = 1'b0;
        eff_size = a_size;
        eff_off  = a_addr[1:0];
`ifdef DMEM_ERR_EN
        acc_err = (a_size == MEM_BAD)
               || (a_size == MEM_HALF && a_addr[0])
               || (a_size == MEM_WORD && a_addr[1:0] != 2'b00);
`else
        case (a_size)
            MEM_HALF: eff_off = {a_addr[1], 1'b0};
            MEM_WORD: eff_off = 2'b00;
            MEM_BAD: begin
                eff_size = MEM_WORD;
                eff_off  = 2'b00;
            end
            default: ;
        endcase
`endif
    end

    assign commit = (state_d == ST_RESP);
    assign idx    = a_addr[AW+1:2];
    assign rword  = mem[idx];

    dmem_lane_align u_lane_align (
        .size       (eff_size),
        .offset     (eff_off),
        .uns        (a_unsigned),
        .wdata      (a_wdata),
        .rword      (rword),
        .be         (be),
        .wdata_lane (wdata_lane),
        .load_data  (load_data)
    );

    always_comb begin
        wr_word = rword;
        for (int j = 0; j < 4; j++) begin
            if (be[j]) wr_word[8*j +: 8] = wdata_lane[8*j +: 8];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NO_OF_WORDS; i++) mem[i] <= 32'h0;
        end else if (commit && a_we && !acc_err) begin
            mem[idx] <= wr_word;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ready_o  <= 1'b1;
            rvalid_o <= 1'b0;
            rdata_o  <= 32'h0;
            err_o    <= 1'b0;
        end else begin
            ready_o  <= (state_d == ST_IDLE);
            rvalid_o <= commit;
            if (commit) begin
                rdata_o <= (a_we || acc_err) ? 32'h0 : load_data;
                err_o   <= acc_err;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Scoreboard bench for data_mem_lsu: a byte-array reference model predicts each
// response, and a monitor checks data, error flag and latency on every rvalid_o.
module tb_data_mem_lsu;

    localparam int WS     = 3;
    localparam int KB     = 1;
    localparam int NBYTES = KB * 1024;
`ifdef DMEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i, we_i, unsigned_i;
    logic [1:0]  size_i;
    logic [31:0] addr_i, wdata_i;
    logic        ready_o, rvalid_o, err_o;
    logic [31:0] rdata_o;

    data_mem_lsu #(.MEM_SIZE_IN_KB(KB), .WAIT_STATES(WS)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .we_i       (we_i),
        .size_i     (size_i),
        .unsigned_i (unsigned_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .ready_o    (ready_o),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          c;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   ntests = 0;
    int   nfail  = 0;
    logic [7:0] mb [NBYTES];

    function automatic void model_clear();
        for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;
    endfunction

    // Little-endian byte memory; upper address bits alias away.
    function automatic void model_access(input logic we, input logic [1:0] sz, input logic uns,
                                         input logic [31:0] addr, input logic [31:0] wd,
                                         output logic [31:0] rd, output logic er);
        int a;
        int n;
        logic [1:0] s;
        logic [31:0] v;
        a  = int'(addr % NBYTES);
        s  = sz;
        rd = 32'h0;
        er = 1'b0;
        v  = 32'h0;
        if (ERR_EN && (s == 2'd3 || (s == 2'd1 && a % 2 != 0) || (s == 2'd2 && a % 4 != 0))) begin
            er = 1'b1;
            return;
        end
        if (s == 2'd3) s = 2'd2;
        n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        a = a - (a % n);
        if (we) begin
            for (int i = 0; i < n; i++) mb[a + i] = wd[8*i +: 8];
        end else begin
            for (int i = 0; i < n; i++) v = v | (32'(mb[a + i]) << (8 * i));
            if (n < 4 && !uns && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
            rd = v;
        end
    endfunction

    task automatic issue(input string name, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input bit directed,
                         input logic [31:0] dexp, input logic derr, input bit expect_resp);
        int   guard;
        exp_t e;
        logic [31:0] md;
        logic        me;
        guard = 0;
        @(negedge clk_i);
        while (!ready_o && guard < 100) begin
            guard++;
            @(negedge clk_i);
        end
        if (!ready_o) begin
            ntests++;
            nfail++;
            $display("FAIL ready_timeout %s: ready_o=%0b required 1", name, ready_o);
            return;
        end
        req_i = 1'b1; we_i = we; size_i = sz; unsigned_i = uns; addr_i = addr; wdata_i = wd;
        model_access(we, sz, uns, addr, wd, md, me);
        if (expect_resp) begin
            e.d = directed ? dexp : md;
            e.e = directed ? derr : me;
            e.c = cyc + WS + 1;
            e.name = name;
            sb_q.push_back(e);
        end
        @(negedge clk_i);
        req_i = 1'b0;
    endtask

    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_i && rvalid_o) begin
            if (sb_q.size() == 0) begin
                ntests++;
                nfail++;
                $display("FAIL unexpected_rvalid: rvalid_o=1 at cycle %0d, required no response", cyc);
            end else begin
                e = sb_q.pop_front();
                ntests++;
                if (rdata_o !== e.d || err_o !== e.e) begin
                    nfail++;
                    $display("FAIL %s: rdata_o=%h err_o=%0b required rdata_o=%h err_o=%0b",
                             e.name, rdata_o, err_o, e.d, e.e);
                end
                ntests++;
                if (cyc != e.c) begin
                    nfail++;
                    $display("FAIL %s_latency: response at cycle %0d required cycle %0d", e.name, cyc, e.c);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        ntests++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        exp_t e;
        logic [31:0] md;
        logic        me;
        logic [1:0]  rsz;
        req_i = 0; we_i = 0; size_i = 0; unsigned_i = 0; addr_i = 0; wdata_i = 0;
        rst_i = 1'b1;
        model_clear();
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("reset_ready", 32'(ready_o), 32'd1);
        check("reset_rvalid", 32'(rvalid_o), 32'd0);
        check("reset_rdata", rdata_o, 32'h0);
        check("reset_err", 32'(err_o), 32'd0);

        issue("lw_0x10_after_reset", 0, 2'd2, 0, 32'h10, 0, 1, 32'h0, 0, 1);
        issue("sw_0x0", 1, 2'd2, 0, 32'h0, 32'hDEADBEEF, 1, 32'h0, 0, 1);
        issue("lb_0x3", 0, 2'd0, 0, 32'h3, 0, 1, 32'hFFFFFFDE, 0, 1);
        issue("lbu_0x3", 0, 2'd0, 1, 32'h3, 0, 1, 32'h000000DE, 0, 1);
        issue("lh_0x0", 0, 2'd1, 0, 32'h0, 0, 1, 32'hFFFFBEEF, 0, 1);
        issue("lhu_0x2", 0, 2'd1, 1, 32'h2, 0, 1, 32'h0000DEAD, 0, 1);
        issue("sw_0x4", 1, 2'd2, 0, 32'h4, 32'h11223344, 1, 32'h0, 0, 1);
        issue("sb_0x5", 1, 2'd0, 0, 32'h5, 32'h000000AA, 1, 32'h0, 0, 1);
        issue("lw_0x4_after_sb", 0, 2'd2, 0, 32'h4, 0, 1, 32'h1122AA44, 0, 1);
        issue("sw_misaligned_0x6", 1, 2'd2, 0, 32'h6, 32'hCAFEF00D, 1, 32'h0, ERR_EN, 1);
        issue("lw_0x4_after_misaligned", 0, 2'd2, 0, 32'h4, 0, 1,
              ERR_EN ? 32'h1122AA44 : 32'hCAFEF00D, 0, 1);
        issue("lw_alias_0x404", 0, 2'd2, 0, 32'h0000_0404, 0, 1,
              ERR_EN ? 32'h1122AA44 : 32'hCAFEF00D, 0, 1);

        // Request held high: first accepted, ignored while busy, second taken on return to IDLE.
        @(negedge clk_i);
        while (!ready_o) @(negedge clk_i);
        req_i = 1; we_i = 1; size_i = 2'd2; unsigned_i = 0; addr_i = 32'h20; wdata_i = 32'hA5A55A5A;
        model_access(1, 2'd2, 0, 32'h20, 32'hA5A55A5A, md, me);
        e.d = 32'h0; e.e = 1'b0; e.c = cyc + WS + 1; e.name = "held_sw_0x20";
        sb_q.push_back(e);
        @(negedge clk_i);
        cnt = 0;
        while (!ready_o && cnt < 20) begin
            cnt++;
            @(negedge clk_i);
        end
        check("held_ready_low_cycles", 32'(cnt), 32'(WS + 1));
        we_i = 0; addr_i = 32'h20;
        model_access(0, 2'd2, 0, 32'h20, 0, md, me);
        e.d = 32'hA5A55A5A; e.e = 1'b0; e.c = cyc + WS + 1; e.name = "held_lw_0x20";
        sb_q.push_back(e);
        @(negedge clk_i);
        req_i = 0;

        // Reset during the wait phase of a store: no response, store discarded.
        issue("sw_0x8_aborted", 1, 2'd2, 0, 32'h8, 32'h12345678, 0, 0, 0, 0);
        rst_i = 1'b1;
        model_clear();
        @(negedge clk_i);
        rst_i = 1'b0;
        check("abort_rvalid", 32'(rvalid_o), 32'd0);
        check("abort_ready", 32'(ready_o), 32'd1);
        repeat (WS + 2) @(negedge clk_i);
        issue("lw_0x8_after_abort", 0, 2'd2, 0, 32'h8, 0, 1, 32'h0, 0, 1);

        for (int k = 0; k < 200; k++) begin
            rsz = 2'($urandom_range(0, 3));
            issue("random_access", 1'($urandom_range(0, 1)), rsz, 1'($urandom_range(0, 1)),
                  $urandom & 32'hFFFF_FC3F, $urandom, 0, 0, 0, 1);
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
        end

        cnt = 0;
        while (sb_q.size() != 0 && cnt < 50) begin
            cnt++;
            @(negedge clk_i);
        end
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/data_mem_lsu.md
DATA_MEM_LSU -- requirements
Module: data_mem_lsu

Interface
REQ-001 SHALL have parameter MEM_SIZE_IN_KB, default 1, memory capacity in KB.
REQ-002 SHALL have parameter WAIT_STATES, default 0, extra access cycles between acceptance and response (0..15).
REQ-003 SHALL derive localparam NO_OF_WORDS = MEM_SIZE_IN_KB*256 and AW = $clog2(NO_OF_WORDS).
REQ-004 SHALL have port clk_i, input, 1, clock.
REQ-005 SHALL have port rst_i, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL have port req_i, input, 1, access request.
REQ-007 SHALL have port we_i, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have port size_i, input, 2, 00 byte, 01 half, 10 word, 11 illegal.
REQ-009 SHALL have port unsigned_i, input, 1, zero-extend loads.
REQ-010 SHALL have port addr_i, input, 32, byte address.
REQ-011 SHALL have port wdata_i, input, 32, store data, right-aligned.
REQ-012 SHALL have port ready_o, output, 1, block idle and accepting.
REQ-013 SHALL have port rvalid_o, output, 1, one-cycle response strobe.
REQ-014 SHALL have port rdata_o, output, 32, extended load data.
REQ-015 SHALL have port err_o, output, 1, access error, valid with rvalid_o.

Function
REQ-016 SHALL hold NO_OF_WORDS x 32-bit words indexed by addr[AW+1:2]; upper address bits ignored (aliasing).
REQ-017 SHALL implement FSM IDLE, WAIT, RESP; ready_o = 1 only in IDLE.
REQ-018 SHALL accept on req_i && ready_o, registering addr, we, size, unsigned, wdata; IDLE->WAIT if WAIT_STATES>0, else IDLE->RESP.
REQ-019 SHALL stay in WAIT exactly WAIT_STATES cycles via down-counter, then go to RESP.
REQ-020 SHALL assert rvalid_o for exactly the one RESP cycle, then return to IDLE; response latency = WAIT_STATES+1 cycles after acceptance.
REQ-021 SHALL ignore req_i outside IDLE (no queueing).
REQ-022 SHALL commit stores and register load data on the edge entering RESP.
REQ-023 SHALL write SB to lane addr[1:0], SH to lanes {addr[1],0}/{addr[1],1}, SW all lanes; wdata low byte/half replicated to lane; other lanes unchanged.
REQ-024 SHALL return loads lane-extracted, sign-extended unless unsigned_i; word loads ignore unsigned_i.
REQ-025 SHALL drive rdata_o = 0 on store responses.
REQ-026 SHALL register all outputs; no combinational path from inputs to rvalid_o/rdata_o/err_o.

Reset
REQ-027 SHALL on rst_i force IDLE, counter 0, rvalid_o 0, rdata_o 0, err_o 0, all memory words 0.
REQ-028 SHALL abort an in-flight access on rst_i: uncommitted store discarded, no rvalid_o.

Configuration
REQ-029 SHALL use macro DMEM_ERR_EN for error detection.
REQ-030 With DMEM_ERR_EN: misaligned (half addr[0]=1, word addr[1:0]!=0) or size_i=11 gives err_o=1 with rvalid_o, rdata_o=0, no write.
REQ-031 Without DMEM_ERR_EN: err_o tied 0, misaligned low address bits masked to alignment, size_i=11 treated as word.

Structure
REQ-032 SHALL place mem_size_e (MEM_BYTE, MEM_HALF, MEM_WORD, MEM_BAD) and FSM state enum in package dmem_pkg.
REQ-033 SHALL put lane byte-enable/write alignment and load extraction in combinational sub-module dmem_lane_align.

Verification
REQ-034 Reset, LW 0x10 -> rvalid_o at cycle WAIT_STATES+1, rdata_o 0x00000000, err_o 0.
REQ-035 SW 0x0 0xDEADBEEF; LB 0x3 -> 0xFFFFFFDE; LBU 0x3 -> 0x000000DE; LH 0x0 -> 0xFFFFBEEF; LHU 0x2 -> 0x0000DEAD.
REQ-036 SW 0x4 0x11223344, SB 0x5 0x000000AA, LW 0x4 -> 0x1122AA44.
REQ-037 SW 0x6 0xCAFEF00D: with DMEM_ERR_EN err_o=1, LW 0x4 unchanged; without, LW 0x4 -> 0xCAFEF00D.
REQ-038 WAIT_STATES=3, req_i held high -> ready_o low 4 cycles, second request accepted only on return to IDLE.
REQ-039 rst_i pulsed during WAIT of SW 0x8 0x12345678 -> no rvalid_o, LW 0x8 -> 0x00000000.
